// File: rtl/id_stage.sv
// id_stage: IF/ID register, 32x32 register file, field/control decode,
// load-use hazard detection and the registered ID/EX bundle.
module id_stage #(
  parameter int NREGS  = 32,
  parameter int RA_REG = 31
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_inst,
  input  logic        if_valid,
  input  logic        flush,
  input  logic        wb_we,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        stall,
  output logic        ex_valid,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_rs_data,
  output logic [31:0] ex_rt_data,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_rs,
  output logic [4:0]  ex_rt,
  output logic [4:0]  ex_dst,
  output logic [5:0]  ex_opcode,
  output logic [5:0]  ex_funct,
  output logic        ex_reg_we,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        ex_branch,
  output logic        ex_jump,
  output logic        ex_illegal
);

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dst;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        reg_we;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic        illegal;
  } id_ex_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ADIU = 6'h09;
  localparam logic [5:0] OP_SLTI = 6'h0A;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LUI  = 6'h0F;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] FN_JR   = 6'h08;

  logic [31:0] id_pc_q;
  logic [31:0] id_inst_q;
  logic        id_valid_q;
  logic [31:0] rf_q [NREGS];
  id_ex_t      ex_q;
  id_ex_t      ex_d;
  id_ex_t      dec;

  logic [5:0]  op;
  logic [5:0]  fn;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [15:0] imm16;
  logic [31:0] rs_rd;
  logic [31:0] rt_rd;
  logic        uses_rt;
  logic        op_r;
  logic        op_lw;
  logic        op_sw;
  logic        op_br;
  logic        op_alui;
  logic        op_j;
  logic        op_jal;
  logic        zext;

  assign op    = id_inst_q[31:26];
  assign rs    = id_inst_q[25:21];
  assign rt    = id_inst_q[20:16];
  assign rd    = id_inst_q[15:11];
  assign fn    = id_inst_q[5:0];
  assign imm16 = id_inst_q[15:0];

  assign op_r    = op == OP_R;
  assign op_lw   = op == OP_LW;
  assign op_sw   = op == OP_SW;
  assign op_br   = (op == OP_BEQ) || (op == OP_BNE);
  assign op_alui = op inside {OP_ADDI, OP_ADIU, OP_SLTI,
                             OP_ANDI, OP_ORI, OP_LUI};
  assign op_j    = op == OP_J;
  assign op_jal  = op == OP_JAL;
  assign zext    = op inside {OP_ANDI, OP_ORI, OP_LUI};

  // IF/ID register: flush kills, stall holds, otherwise capture fetch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_pc_q    <= '0;
      id_inst_q  <= '0;
      id_valid_q <= 1'b0;
    end else if (flush) begin
      id_valid_q <= 1'b0;
    end else if (!stall) begin
      id_pc_q    <= if_pc;
      id_inst_q  <= if_inst;
      id_valid_q <= if_valid;
    end
  end

  // Register file write port; $0 is never written
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else if (wb_we && (wb_addr != 5'd0)) begin
      rf_q[wb_addr] <= wb_data;
    end
  end

  // Read ports with same-cycle writeback bypass
  always_comb begin
    rs_rd = rf_q[rs];
    rt_rd = rf_q[rt];
    if (rs == 5'd0) rs_rd = '0;
    else if (wb_we && (wb_addr == rs)) rs_rd = wb_data;
    if (rt == 5'd0) rt_rd = '0;
    else if (wb_we && (wb_addr == rt)) rt_rd = wb_data;
  end

  // Field and control decode of the instruction held in IF/ID
  always_comb begin
    dec         = '0;
    uses_rt     = 1'b0;
    dec.valid   = 1'b1;
    dec.pc      = id_pc_q;
    dec.rs_data = rs_rd;
    dec.rt_data = rt_rd;
    dec.imm     = zext ? {16'h0, imm16} : {{16{imm16[15]}}, imm16};
    dec.rs      = rs;
    dec.rt      = rt;
    dec.opcode  = op;
    dec.funct   = fn;
    unique case (1'b1)
      op_r: begin
        dec.reg_we = fn != FN_JR;
        dec.jump   = fn == FN_JR;
        dec.dst    = rd;
        uses_rt    = 1'b1;
      end
      op_lw: begin
        dec.mem_read = 1'b1;
        dec.reg_we   = 1'b1;
        dec.dst      = rt;
      end
      op_sw: begin
        dec.mem_write = 1'b1;
        uses_rt       = 1'b1;
      end
      op_br: begin
        dec.branch = 1'b1;
        uses_rt    = 1'b1;
      end
      op_alui: begin
        dec.reg_we = 1'b1;
        dec.dst    = rt;
      end
      op_j: dec.jump = 1'b1;
      op_jal: begin
        dec.jump   = 1'b1;
        dec.reg_we = 1'b1;
        dec.dst    = 5'(RA_REG);
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  // Load-use hazard against the load currently in EX
  assign stall = id_valid_q && ex_q.valid && ex_q.mem_read &&
                 (ex_q.dst != 5'd0) &&
                 ((ex_q.dst == rs) || (uses_rt && (ex_q.dst == rt)));

  // Bubble on flush, stall or empty IF/ID
  always_comb begin
    ex_d = dec;
    if (flush || stall || !id_valid_q) ex_d = '0;
  end

  // ID/EX register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ex_q <= '0;
    else        ex_q <= ex_d;
  end

  assign ex_valid     = ex_q.valid;
  assign ex_pc        = ex_q.pc;
  assign ex_rs_data   = ex_q.rs_data;
  assign ex_rt_data   = ex_q.rt_data;
  assign ex_imm       = ex_q.imm;
  assign ex_rs        = ex_q.rs;
  assign ex_rt        = ex_q.rt;
  assign ex_dst       = ex_q.dst;
  assign ex_opcode    = ex_q.opcode;
  assign ex_funct     = ex_q.funct;
  assign ex_reg_we    = ex_q.reg_we;
  assign ex_mem_read  = ex_q.mem_read;
  assign ex_mem_write = ex_q.mem_write;
  assign ex_branch    = ex_q.branch;
  assign ex_jump      = ex_q.jump;
  assign ex_illegal   = ex_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed and random stimulus for id_stage,
// checked against an instruction-level reference model.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] if_pc, if_inst, wb_data;
  logic        if_valid, flush, wb_we;
  logic [4:0]  wb_addr;
  logic        stall, ex_valid;
  logic [31:0] ex_pc, ex_rs_data, ex_rt_data, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_dst;
  logic [5:0]  ex_opcode, ex_funct;
  logic        ex_reg_we, ex_mem_read, ex_mem_write;
  logic        ex_branch, ex_jump, ex_illegal;

  always #5 clk = ~clk;

  id_stage dut (
    .clk(clk), .rst_n(rst_n),
    .if_pc(if_pc), .if_inst(if_inst), .if_valid(if_valid),
    .flush(flush),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .stall(stall), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
    .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_dst(ex_dst), .ex_opcode(ex_opcode), .ex_funct(ex_funct),
    .ex_reg_we(ex_reg_we), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_branch(ex_branch),
    .ex_jump(ex_jump), .ex_illegal(ex_illegal)
  );

  typedef struct packed {
    logic        valid;
    logic [31:0] pc, rsd, rtd, imm;
    logic [4:0]  rs, rt, dst;
    logic [5:0]  op, fn;
    logic        we, mr, mw, br, jp, il;
  } exb_t;

  typedef struct packed {
    logic        v;
    logic [31:0] pc;
    logic [31:0] inst;
  } idm_t;

  exb_t        ex_m;
  idm_t        id_m;
  logic [31:0] rf_m [32];
  int          checks = 0;
  int          fails = 0;

  function automatic logic [31:0] rtype(input logic [4:0] s, t, d,
                                        input logic [5:0] f);
    return {6'h00, s, t, d, 5'h00, f};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] o,
                                        input logic [4:0] s, t,
                                        input logic [15:0] i);
    return {o, s, t, i};
  endfunction

  function automatic exb_t decode_m(input logic [31:0] pc, inst);
    exb_t       d = '0;
    logic [5:0] o = inst[31:26];
    d.valid = 1'b1;
    d.pc    = pc;
    d.rs    = inst[25:21];
    d.rt    = inst[20:16];
    d.op    = o;
    d.fn    = inst[5:0];
    d.rsd   = rf_m[d.rs];
    d.rtd   = rf_m[d.rt];
    if (o == 6'h0C || o == 6'h0D || o == 6'h0F)
      d.imm = {16'h0, inst[15:0]};
    else
      d.imm = {{16{inst[15]}}, inst[15:0]};
    case (o)
      6'h00: begin
        d.jp  = inst[5:0] == 6'h08;
        d.we  = !d.jp;
        d.dst = inst[15:11];
      end
      6'h23: begin d.mr = 1'b1; d.we = 1'b1; d.dst = d.rt; end
      6'h2B: d.mw = 1'b1;
      6'h04, 6'h05: d.br = 1'b1;
      6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0F: begin
        d.we = 1'b1; d.dst = d.rt;
      end
      6'h02: d.jp = 1'b1;
      6'h03: begin d.jp = 1'b1; d.we = 1'b1; d.dst = 5'd31; end
      default: d.il = 1'b1;
    endcase
    return d;
  endfunction

  function automatic logic uses_rt_m(input logic [31:0] inst);
    logic [5:0] o = inst[31:26];
    return o == 6'h00 || o == 6'h2B || o == 6'h04 || o == 6'h05;
  endfunction

  function automatic logic stall_m();
    logic [4:0] s = id_m.inst[25:21];
    logic [4:0] t = id_m.inst[20:16];
    return id_m.v && ex_m.valid && ex_m.mr && ex_m.dst != 5'd0 &&
           (ex_m.dst == s || (uses_rt_m(id_m.inst) && ex_m.dst == t));
  endfunction

  function automatic exb_t obs_f();
    return {ex_valid, ex_pc, ex_rs_data, ex_rt_data, ex_imm,
            ex_rs, ex_rt, ex_dst, ex_opcode, ex_funct,
            ex_reg_we, ex_mem_read, ex_mem_write,
            ex_branch, ex_jump, ex_illegal};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) rf_m[i] = '0;
    ex_m = '0;
    id_m = '0;
  endtask

  // One clock edge of the reference: writes land before same-cycle reads
  task automatic step_model();
    logic s = stall_m();
    if (wb_we && wb_addr != 5'd0) rf_m[wb_addr] = wb_data;
    if (flush || s || !id_m.v) ex_m = '0;
    else ex_m = decode_m(id_m.pc, id_m.inst);
    if (flush) id_m.v = 1'b0;
    else if (!s) id_m = '{if_valid, if_pc, if_inst};
  endtask

  task automatic chk32(input string tag, input logic [31:0] o, e);
    checks++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic chkb(input string tag, input exb_t o, e);
    checks++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic check_all();
    exb_t o = obs_f();
    exb_t e = ex_m;
    if (!e.we) begin
      o.dst = '0;
      e.dst = '0;
    end
    chkb("ex_bundle", o, e);
    chk32("stall", 32'(stall), 32'(stall_m()));
  endtask

  task automatic cyc(input logic [31:0] pc, inst, input logic v, fl,
                     input logic we, input logic [4:0] wa,
                     input logic [31:0] wd);
    if_pc    = pc;
    if_inst  = inst;
    if_valid = v;
    flush    = fl;
    wb_we    = we;
    wb_addr  = wa;
    wb_data  = wd;
    step_model();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  function automatic logic [31:0] rand_inst();
    int         k  = $urandom_range(0, 15);
    logic [4:0] s  = 5'($urandom_range(0, 7));
    logic [4:0] t  = 5'($urandom_range(0, 7));
    logic [4:0] d  = 5'($urandom_range(0, 7));
    logic [15:0] i = 16'($urandom);
    case (k)
      0, 1:    return rtype(s, t, d, 6'h20);
      2:       return rtype(s, t, d, 6'h08);
      3, 4, 5: return itype(6'h23, s, t, i);
      6:       return itype(6'h2B, s, t, i);
      7:       return itype(6'h04, s, t, i);
      8:       return itype(6'h05, s, t, i);
      9:       return itype(6'h08, s, t, i);
      10:      return itype(6'h0C, s, t, i);
      11:      return itype(6'h0D, s, t, i);
      12:      return itype(6'h0F, s, t, i);
      13:      return {6'h02, s, t, i};
      14:      return {6'h03, s, t, i};
      default: return {6'h3F, s, t, i};
    endcase
  endfunction

  initial begin
    logic [31:0] pc;
    logic [31:0] inst;
    logic        v;
    if_pc = '0; if_inst = '0; if_valid = 1'b0; flush = 1'b0;
    wb_we = 1'b0; wb_addr = '0; wb_data = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_all();
    rst_n = 1'b1;

    // Same-cycle writeback bypass, and $0 immune to writes
    cyc(32'h100, rtype(5, 0, 3, 6'h20), 1, 0, 0, 0, 0);
    cyc(32'h104, 32'h0, 0, 0, 1, 5, 32'hDEAD_BEEF);
    chk32("bypass_rs", ex_rs_data, 32'hDEAD_BEEF);
    cyc(32'h108, rtype(0, 5, 3, 6'h20), 1, 0, 1, 0, 32'h1234);
    cyc(32'h10C, 32'h0, 0, 0, 0, 0, 0);
    chk32("r0_zero", ex_rs_data, 32'h0);
    chk32("r5_kept", ex_rt_data, 32'hDEAD_BEEF);

    // Load-use: one stall cycle, one bubble, then the consumer
    cyc(32'h200, itype(6'h23, 1, 8, 16'h0), 1, 0, 0, 0, 0);
    cyc(32'h204, rtype(8, 2, 9, 6'h20), 1, 0, 0, 0, 0);
    chk32("lu_stall", 32'(stall), 32'd1);
    cyc(32'h204, rtype(8, 2, 9, 6'h20), 1, 0, 0, 0, 0);
    chk32("lu_bubble", 32'(ex_valid), 32'd0);
    chk32("lu_stall_once", 32'(stall), 32'd0);
    cyc(32'h208, 32'h0, 0, 0, 0, 0, 0);
    chk32("lu_add_valid", 32'(ex_valid), 32'd1);
    chk32("lu_add_rs", 32'(ex_rs), 32'd8);

    // No stall on $0 destination; sw uses rt
    cyc(32'h300, itype(6'h23, 1, 0, 16'h0), 1, 0, 0, 0, 0);
    cyc(32'h304, rtype(0, 2, 9, 6'h20), 1, 0, 0, 0, 0);
    chk32("r0_nostall", 32'(stall), 32'd0);
    cyc(32'h308, itype(6'h23, 1, 8, 16'h4), 1, 0, 0, 0, 0);
    cyc(32'h30C, itype(6'h2B, 3, 8, 16'h0), 1, 0, 0, 0, 0);
    chk32("sw_rt_stall", 32'(stall), 32'd1);

    // Flush while stalled
    cyc(32'h30C, itype(6'h2B, 3, 8, 16'h0), 1, 1, 0, 0, 0);
    chk32("fl_ex_valid", 32'(ex_valid), 32'd0);
    chk32("fl_stall", 32'(stall), 32'd0);
    cyc(32'h310, 32'h0, 0, 0, 0, 0, 0);
    chk32("fl_id_killed", 32'(ex_valid), 32'd0);

    // Immediate extension and control decode
    cyc(32'h400, itype(6'h0D, 4, 4, 16'h8000), 1, 0, 0, 0, 0);
    cyc(32'h404, 32'h0, 0, 0, 0, 0, 0);
    chk32("ori_imm", ex_imm, 32'h0000_8000);
    cyc(32'h408, itype(6'h08, 1, 2, 16'h8000), 1, 0, 0, 0, 0);
    cyc(32'h40C, 32'h0, 0, 0, 0, 0, 0);
    chk32("addi_imm", ex_imm, 32'hFFFF_8000);
    cyc(32'h410, {6'h03, 26'h40}, 1, 0, 0, 0, 0);
    cyc(32'h414, 32'h0, 0, 0, 0, 0, 0);
    chk32("jal_dst", 32'(ex_dst), 32'd31);
    chk32("jal_we", 32'(ex_reg_we), 32'd1);
    cyc(32'h418, {6'h3F, 26'h123}, 1, 0, 0, 0, 0);
    cyc(32'h41C, 32'h0, 0, 0, 0, 0, 0);
    chk32("ill_flag", 32'(ex_illegal), 32'd1);
    chk32("ill_we", 32'(ex_reg_we), 32'd0);

    // Reset asserted mid-stall clears everything at once
    cyc(32'h500, itype(6'h23, 1, 8, 16'h0), 1, 0, 0, 0, 0);
    cyc(32'h504, rtype(8, 2, 9, 6'h20), 1, 0, 0, 0, 0);
    chk32("pre_rst_stall", 32'(stall), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chkb("rst_ex", obs_f(), '0);
    chk32("rst_stall", 32'(stall), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(32'h600, rtype(5, 0, 3, 6'h20), 1, 0, 0, 0, 0);
    cyc(32'h604, 32'h0, 0, 0, 0, 0, 0);
    chk32("rst_rf_zero", ex_rs_data, 32'h0);

    // Random traffic; fetch holds its instruction while stalled
    pc = 32'h1000;
    inst = rand_inst();
    v = 1'b1;
    for (int n = 0; n < 800; n++) begin
      if (!stall_m()) begin
        pc   = pc + 32'd4;
        inst = rand_inst();
        v    = $urandom_range(0, 7) != 0;
      end
      cyc(pc, inst, v, $urandom_range(0, 15) == 0,
          $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)),
          $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
